// File: rtl/alu_result_checker.sv
// Reference checker for the 8-bit ALU: latency-matched compare, stats, first-error capture.
// Optional: define CHK_HALT_ON_ERR_EN to leave RUN on the first mismatch.
module alu_result_checker #(
    parameter int LAT     = 0,
    parameter int NUM_VEC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        vld,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [2:0]  op,
    input  logic [7:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] chk_cnt,
    output logic [15:0] err_cnt,
    output logic        err_flag,
    output logic [7:0]  err_a,
    output logic [7:0]  err_b,
    output logic [2:0]  err_op,
    output logic [7:0]  err_exp,
    output logic [7:0]  err_got
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [15:0] NV = 16'(NUM_VEC);

    state_t      state, nxt;
    logic        acc, cmp, mis, drained, zero_stats, lim, hit, halt;
    logic [15:0] acc_cnt;
    logic [7:0]  c_a, c_b, c_e;
    logic [2:0]  c_op;

    function automatic logic [7:0] ref_f(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic [2:0] o);
        logic [7:0] r;
        r = '0;
        case (o)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = ~x;
            3'd6: r = {x[6:0], 1'b0};
            3'd7: r = {1'b0, x[7:1]};
        endcase
        return r;
    endfunction

    // acceptance is limited by vectors taken, so in-flight ones never overshoot NUM_VEC
    assign lim = (NUM_VEC != 0) && (acc_cnt >= NV);
    assign acc = vld && (state == RUN) && !lim;

    generate
        if (LAT == 0) begin : g_comb
            assign cmp     = acc;
            assign c_a     = a;
            assign c_b     = b;
            assign c_op    = op;
            assign c_e     = ref_f(a, b, op);
            assign drained = 1'b1;
        end else begin : g_pipe
            logic [LAT-1:0] pv;
            logic [7:0]     pa [LAT];
            logic [7:0]     pb [LAT];
            logic [7:0]     pe [LAT];
            logic [2:0]     po [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        pa[i] <= '0;
                        pb[i] <= '0;
                        pe[i] <= '0;
                        po[i] <= '0;
                    end
                end else begin
                    pv[0] <= acc;
                    pa[0] <= a;
                    pb[0] <= b;
                    po[0] <= op;
                    pe[0] <= ref_f(a, b, op);
                    for (int i = 1; i < LAT; i++) begin
                        pv[i] <= pv[i-1];
                        pa[i] <= pa[i-1];
                        pb[i] <= pb[i-1];
                        po[i] <= po[i-1];
                        pe[i] <= pe[i-1];
                    end
                end
            end

            assign cmp     = pv[LAT-1];
            assign c_a     = pa[LAT-1];
            assign c_b     = pb[LAT-1];
            assign c_op    = po[LAT-1];
            assign c_e     = pe[LAT-1];
            assign drained = ~|pv;
        end
    endgenerate

    assign mis        = cmp && (c_e != dut_out);
    assign hit        = (NUM_VEC != 0) && cmp && (chk_cnt == NV - 16'd1);
    assign zero_stats = ((state == IDLE) && start) || ((state == DONE) && clear);

`ifdef CHK_HALT_ON_ERR_EN
    assign halt = mis && !err_flag;
`else
    assign halt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (start) nxt = RUN;
            RUN:   if (stop || hit || halt) nxt = DRAIN;
            DRAIN: if (drained) nxt = DONE;
            DONE:  if (clear) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt  <= '0;
            chk_cnt  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            err_a    <= '0;
            err_b    <= '0;
            err_op   <= '0;
            err_exp  <= '0;
            err_got  <= '0;
        end else if (zero_stats) begin
            acc_cnt  <= '0;
            chk_cnt  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            err_a    <= '0;
            err_b    <= '0;
            err_op   <= '0;
            err_exp  <= '0;
            err_got  <= '0;
        end else begin
            if (acc && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
            if (cmp && chk_cnt != 16'hFFFF) chk_cnt <= chk_cnt + 16'd1;
            if (mis && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (mis && !err_flag) begin
                err_flag <= 1'b1;
                err_a    <= c_a;
                err_b    <= c_b;
                err_op   <= c_op;
                err_exp  <= c_e;
                err_got  <= dut_out;
            end
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == 16'd0);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: LAT=0 unlimited and LAT=2 NUM_VEC=8 instances.
// Expected values are hand-computed constants; honours CHK_HALT_ON_ERR_EN if defined.
module tb_alu_result_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 0, stop0 = 0, clear0 = 0, vld0 = 0;
    logic [7:0]  a0 = 0, b0 = 0, out0 = 0;
    logic [2:0]  op0 = 0;
    logic        busy0, done0, pass0, flag0;
    logic [15:0] chk0, err0;
    logic [7:0]  ea0, eb0, ee0, eg0;
    logic [2:0]  eo0;

    logic        start2 = 0, stop2 = 0, clear2 = 0, vld2 = 0;
    logic [7:0]  a2 = 0, b2 = 0, out2 = 0;
    logic [2:0]  op2 = 0;
    logic        busy2, done2, pass2, flag2;
    logic [15:0] chk2, err2;
    logic [7:0]  ea2, eb2, ee2, eg2;
    logic [2:0]  eo2;

    int checks = 0;
    int errors = 0;

    alu_result_checker #(.LAT(0), .NUM_VEC(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop0), .clear(clear0),
        .vld(vld0), .a(a0), .b(b0), .op(op0), .dut_out(out0),
        .busy(busy0), .done(done0), .pass(pass0), .chk_cnt(chk0),
        .err_cnt(err0), .err_flag(flag0), .err_a(ea0), .err_b(eb0),
        .err_op(eo0), .err_exp(ee0), .err_got(eg0)
    );

    alu_result_checker #(.LAT(2), .NUM_VEC(8)) u2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2), .clear(clear2),
        .vld(vld2), .a(a2), .b(b2), .op(op2), .dut_out(out2),
        .busy(busy2), .done(done2), .pass(pass2), .chk_cnt(chk2),
        .err_cnt(err2), .err_flag(flag2), .err_a(ea2), .err_b(eb2),
        .err_op(eo2), .err_exp(ee2), .err_got(eg2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // LAT=2 stream: a, b, op, expected; entry 8 must be refused
    logic [7:0] ta [9] = '{8'h05, 8'h10, 8'hF0, 8'hF0, 8'hAA, 8'h5A, 8'hC3, 8'hC3, 8'h01};
    logic [7:0] tb [9] = '{8'h03, 8'h01, 8'h3C, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01};
    logic [2:0] to [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [7:0] te [9] = '{8'h08, 8'h0F, 8'h30, 8'hFF, 8'h55, 8'hA5, 8'h86, 8'h61, 8'h02};

    // LAT=0 correct vectors, including wrap cases
    logic [7:0] wa [7] = '{8'hFF, 8'h00, 8'h81, 8'h81, 8'h0F, 8'h3C, 8'h30};
    logic [7:0] wb [7] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h0C};
    logic [2:0] wo [7] = '{3'd0, 3'd1, 3'd6, 3'd7, 3'd5, 3'd4, 3'd3};
    logic [7:0] we [7] = '{8'h00, 8'hFF, 8'h02, 8'h40, 8'hF0, 8'h33, 8'h3C};

    initial begin
        int exp_err, exp_chk;
        tick();
        tick();
        chk("rst_busy", 16'(busy0), 16'd0);
        chk("rst_done", 16'(done0), 16'd0);
        chk("rst_pass", 16'(pass0), 16'd0);
        chk("rst_chk", chk0, 16'd0);
        chk("rst_flag", 16'(flag0), 16'd0);
        rst = 1'b0;
        tick();

        // basic pass run
        start0 = 1; tick(); start0 = 0;
        chk("start_busy", 16'(busy0), 16'd1);
        vld0 = 1; a0 = 8'h05; b0 = 8'h03; op0 = 3'd0; out0 = 8'h08;
        tick();
        vld0 = 0;
        chk("add_chk", chk0, 16'd1);
        chk("add_err", err0, 16'd0);
        stop0 = 1; tick(); stop0 = 0;
        chk("drain_done", 16'(done0), 16'd0);
        tick();
        chk("done", 16'(done0), 16'd1);
        chk("pass", 16'(pass0), 16'd1);
        chk("done_busy", 16'(busy0), 16'd0);

        // error capture run
        clear0 = 1; tick(); clear0 = 0;
        chk("clear_chk", chk0, 16'd0);
        chk("clear_done", 16'(done0), 16'd0);
        start0 = 1; tick(); start0 = 0;
        vld0 = 1; a0 = 8'h10; b0 = 8'h01; op0 = 3'd1; out0 = 8'h0E;
        tick();
        chk("mis_err", err0, 16'd1);
        chk("mis_flag", 16'(flag0), 16'd1);
        chk("mis_exp", 16'(ee0), 16'h0F);
        chk("mis_got", 16'(eg0), 16'h0E);
        chk("mis_op", 16'(eo0), 16'd1);
        chk("mis_a", 16'(ea0), 16'h10);
        chk("mis_b", 16'(eb0), 16'h01);
        a0 = 8'h20; b0 = 8'h22; op0 = 3'd2; out0 = 8'hFF;
        tick();
`ifdef CHK_HALT_ON_ERR_EN
        exp_err = 1;
        exp_chk = 1;
`else
        exp_err = 2;
        exp_chk = 9;
`endif
        chk("mis2_err", err0, 16'(exp_err));
        chk("mis2_keep_exp", 16'(ee0), 16'h0F);
        chk("mis2_keep_a", 16'(ea0), 16'h10);
        for (int i = 0; i < 7; i++) begin
            a0 = wa[i]; b0 = wb[i]; op0 = wo[i]; out0 = we[i];
            tick();
        end
        vld0 = 0;
        chk("wrap_err", err0, 16'(exp_err));
        chk("wrap_chk", chk0, 16'(exp_chk));
        stop0 = 1; tick(); stop0 = 0;
        tick();
        chk("err_done", 16'(done0), 16'd1);
        chk("err_pass", 16'(pass0), 16'd0);

        // LAT=2, NUM_VEC=8 stream with a refused 9th vector
        start2 = 1; tick(); start2 = 0;
        for (int c = 0; c < 11; c++) begin
            vld2 = (c < 9);
            if (c < 9) begin
                a2 = ta[c]; b2 = tb[c]; op2 = to[c];
            end
            out2 = (c >= 2) ? te[c-2] : 8'h00;
            if (c == 10) out2 = 8'hEE;
            tick();
            if (c == 8) chk("l2_chk7", chk2, 16'd7);
            if (c == 9) begin
                chk("l2_chk8", chk2, 16'd8);
                chk("l2_notdone", 16'(done2), 16'd0);
                chk("l2_busy", 16'(busy2), 16'd1);
            end
        end
        vld2 = 0;
        chk("l2_done", 16'(done2), 16'd1);
        chk("l2_pass", 16'(pass2), 16'd1);
        chk("l2_err", err2, 16'd0);
        tick();
        chk("l2_chk_hold", chk2, 16'd8);

        // reset with two vectors in flight
        clear2 = 1; tick(); clear2 = 0;
        start2 = 1; tick(); start2 = 0;
        vld2 = 1; a2 = 8'h05; b2 = 8'h03; op2 = 3'd0; out2 = 8'hEE;
        tick();
        a2 = 8'h10; b2 = 8'h01; op2 = 3'd1;
        tick();
        vld2 = 0;
        rst = 1;
        #1;
        chk("arst_busy2", 16'(busy2), 16'd0);
        chk("arst_chk2", chk2, 16'd0);
        chk("arst_err0", err0, 16'd0);
        chk("arst_flag0", 16'(flag0), 16'd0);
        chk("arst_exp0", 16'(ee0), 16'd0);
        chk("arst_done0", 16'(done0), 16'd0);
        tick();
        rst = 0;
        tick();
        tick();
        tick();
        chk("post_rst_chk", chk2, 16'd0);
        chk("post_rst_err", err2, 16'd0);
        chk("post_rst_busy", 16'(busy2), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Synthesizable response checker for the 8-bit, 3-bit-opcode ALU. It sits on the consumer side of the ALU interface, opposite the stimulus driver. Each cycle it accepts the operand/opcode vector that was presented to the ALU and computes the reference result. After a configurable DUT latency it compares that result with the ALU output, then keeps pass/error statistics and a capture of the first failure, for use in benches and on-chip self-test.

## Interface
Parameters:
- LAT, 0: ALU output latency in cycles; legal 0..3.
- NUM_VEC, 256: vectors to check before auto-finish; 0 = unlimited.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; IDLE -> RUN.
- stop  in  1  pulse; RUN -> DRAIN.
- clear  in  1  pulse; DONE -> IDLE, zeroes statistics.
- vld  in  1  vector on a/b/op is valid this cycle.
- a  in  8  operand A as applied to ALU.
- b  in  8  operand B as applied to ALU.
- op  in  3  opcode as applied to ALU.
- dut_out  in  8  ALU result.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- pass  out  1  done && err_cnt==0.
- chk_cnt  out  16  vectors compared, saturating.
- err_cnt  out  16  mismatches, saturating.
- err_flag  out  1  sticky, first mismatch captured.
- err_a, err_b  out  8  operands of first mismatch.
- err_op  out  3  opcode of first mismatch.
- err_exp, err_got  out  8  expected / DUT value of first mismatch.

## Operation
- Opcode map (result mod 256): 0 a+b, 1 a-b, 2 a&b, 3 a|b, 4 a^b, 5 ~a, 6 a<<1, 7 a>>1 (logical). b is ignored for ops 5-7.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN.
  - RUN: stop -> DRAIN; when the comparison count reaches NUM_VEC (NUM_VEC≠0) -> DRAIN.
  - DRAIN: pipeline empty -> DONE.
  - DONE: clear -> IDLE.
  - start, stop and clear are ignored in all other states.
- Vectors are accepted only when vld && state==RUN. Accepted vectors enter a LAT-deep pipeline that carries {a, b, op, expected}.
- Vectors already in flight at stop are still compared. No new vectors are accepted in DRAIN.
- When NUM_VEC is reached, later vld cycles in the same RUN are not accepted.
- Compare event: the pipeline output stage is valid. chk_cnt increments. On expected≠dut_out, err_cnt increments. On the first mismatch only, err_flag is set and the err_* fields are loaded.
- Counters saturate at 16'hFFFF and do not wrap.
- IDLE->RUN zeroes chk_cnt, err_cnt, err_flag and the err_* fields. clear also zeroes them.

## Timing
- Reset (async, immediate): state IDLE. All outputs 0: busy, done, pass, chk_cnt, err_cnt, err_flag, err_* fields.
- Reset mid-run discards the pipeline contents.
- LAT=0: dut_out is compared in the same cycle as vld. Counters and err_* update at that edge and are visible on the following cycle.
- LAT=N: the vector accepted at edge k is compared against dut_out during cycle k+N. Statistics are visible after edge k+N.
- busy rises the cycle after the start edge. done rises the cycle after the pipeline drains.
- Simultaneous stop and final NUM_VEC compare: one transition to DRAIN, counted once.
- A compare with a mismatch that occurs in the same cycle as saturation leaves err_cnt at FFFF.

## Configuration
- CHK_HALT_ON_ERR_EN defined: the first mismatch forces RUN -> DRAIN in the same edge that sets err_flag.
- CHK_HALT_ON_ERR_EN undefined: mismatches are only counted and checking continues to stop or NUM_VEC.

## Test plan
- LAT=0: start; vld with a=05, b=03, op=0, dut_out=08; stop -> chk_cnt=1, err_cnt=0, done=1, pass=1.
- LAT=0: a=10, b=01, op=1, dut_out=0E -> err_cnt=1, err_flag=1, err_exp=0F, err_got=0E, err_op=1, pass=0 at done. A second mismatch leaves the err_* fields unchanged.
- Wrap: a=FF, b=01, op=0, dut_out=00 -> no error. a=00, b=01, op=1, dut_out=FF -> no error. a=81, op=6, dut_out=02 -> no error.
- LAT=2, NUM_VEC=8: 8 back-to-back correct vectors with dut_out delayed 2 cycles -> done 1 cycle after the 8th compare; a 9th vld is ignored; chk_cnt=8.
- Assert rst during RUN with 2 vectors in flight -> all outputs 0 immediately; no further compares after release until start.
- With CHK_HALT_ON_ERR_EN: mismatch on vector 3 of 10 -> state leaves RUN; chk_cnt=3 (LAT=0); err_cnt=1.
